// File: rtl/unary_mac_pkg.sv
// Shared types and defaults for the unary shift MAC.
// Used by unary_shift_mac; optional saturation is enabled by UNARY_MAC_SAT_EN.
package unary_mac_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    MULT   = 2'd1,
    RESULT = 2'd2
  } state_t;

  localparam int DEF_BIN_BITS  = 4;
  localparam int DEF_NUM_TERMS = 4;

  function automatic int u_bits(input int bin_bits);
    return 1 << bin_bits;
  endfunction

endpackage

// File: rtl/unary_ones_counter.sv
// Saturating ones counter: counts enabled 1-bits up to MAX; clear has priority.
module unary_ones_counter #(
  parameter int W   = 5,
  parameter int MAX = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         bit_val,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && bit_val && (count < W'(MAX))) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/unary_shift_mac.sv
// Unary shift multiply-accumulate: serial unary operand frames in, unary product pulses out,
// binary dot-product result via valid/ready. Define UNARY_MAC_SAT_EN for a clamping accumulator.
//
// state  | meaning
// LOAD   | accepting unary beats of the current operand pair
// MULT   | emitting a_cnt*b_cnt product pulses (one bubble if zero)
// RESULT | holding accumulated sum until res_ready
module unary_shift_mac
  import unary_mac_pkg::*;
#(
  parameter int BIN_BITS  = DEF_BIN_BITS,
  parameter int NUM_TERMS = DEF_NUM_TERMS,
  parameter int ACC_BITS  = 2*BIN_BITS + $clog2(NUM_TERMS) + 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_a,
  input  logic                in_b,
  input  logic                in_valid,
  input  logic                in_last,
  input  logic                in_acc_last,
  output logic                in_ready,
  output logic                out,
  output logic                busy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [ACC_BITS-1:0] res_data,
  output logic                res_sat
);

  localparam int U_BITS = u_bits(BIN_BITS);
  localparam int CNT_W  = BIN_BITS + 1;
  localparam int TERM_W = $clog2(NUM_TERMS + 1);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    a_cnt, b_cnt, i_cnt, j_cnt;
  logic [TERM_W-1:0]   term_cnt;
  logic [ACC_BITS-1:0] acc, acc_nxt;
  logic                acc_last_q;
  logic                accept, pulse, mult_done, zero_prod, i_wrap, j_wrap;

  unary_ones_counter #(.W(CNT_W), .MAX(U_BITS)) u_cnt_a (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (accept),
    .bit_val (in_a),
    .clr     (mult_done),
    .count   (a_cnt)
  );

  unary_ones_counter #(.W(CNT_W), .MAX(U_BITS)) u_cnt_b (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (accept),
    .bit_val (in_b),
    .clr     (mult_done),
    .count   (b_cnt)
  );

  assign zero_prod = (a_cnt == '0) || (b_cnt == '0);
  assign i_wrap    = (i_cnt == a_cnt - CNT_W'(1));
  assign j_wrap    = (j_cnt == b_cnt - CNT_W'(1));

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    pulse     = 1'b0;
    mult_done = 1'b0;
    case (state)
      LOAD: begin
        accept = in_valid;
        if (in_valid && in_last) state_nxt = MULT;
      end
      MULT: begin
        pulse     = !zero_prod;
        mult_done = zero_prod || (i_wrap && j_wrap);
        if (mult_done) begin
          state_nxt = (acc_last_q || (term_cnt == TERM_W'(NUM_TERMS - 1))) ? RESULT : LOAD;
        end
      end
      RESULT: begin
        if (res_ready) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  assign in_ready  = (state == LOAD);
  assign out       = pulse;
  assign busy      = !((state == LOAD) && (term_cnt == '0));
  assign res_valid = (state == RESULT);

`ifdef UNARY_MAC_SAT_EN
  logic sat_q;
  wire  acc_full = &acc;

  assign acc_nxt = (pulse && !acc_full) ? acc + ACC_BITS'(1) : acc;
  assign res_sat = sat_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_q <= 1'b0;
    end else if ((state == RESULT) && res_ready) begin
      sat_q <= 1'b0;
    end else if (pulse && acc_full) begin
      sat_q <= 1'b1;
    end
  end
`else
  assign acc_nxt = pulse ? acc + ACC_BITS'(1) : acc;
  assign res_sat = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= LOAD;
      i_cnt      <= '0;
      j_cnt      <= '0;
      term_cnt   <= '0;
      acc        <= '0;
      acc_last_q <= 1'b0;
      res_data   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      if (accept && in_last) acc_last_q <= in_acc_last;
      if (pulse) begin
        if (i_wrap) begin
          i_cnt <= '0;
          j_cnt <= j_cnt + CNT_W'(1);
        end else begin
          i_cnt <= i_cnt + CNT_W'(1);
        end
      end
      if (mult_done) begin
        i_cnt    <= '0;
        j_cnt    <= '0;
        term_cnt <= term_cnt + TERM_W'(1);
        if (state_nxt == RESULT) res_data <= acc_nxt;
      end
      if ((state == RESULT) && res_ready) begin
        acc      <= '0;
        term_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_unary_shift_mac.sv
// Self-checking bench for unary_shift_mac: directed frames plus random frames vs. an arithmetic model.
`timescale 1ns/1ps
module tb_unary_shift_mac;

  localparam int ACC_W  = 11;
  localparam int ACC8_W = 8;
  localparam int U_MAX  = 16;
  localparam int TERMS  = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic in_a, in_b, in_valid, in_last, in_acc_last, res_ready;
  logic in_ready, out, busy, res_valid, res_sat;
  logic [ACC_W-1:0] res_data;
  logic in_ready8, out8, busy8, res_valid8, res_sat8;
  logic [ACC8_W-1:0] res_data8;

  int checks = 0;
  int errors = 0;
  int m_sum = 0;
  int m_terms = 0;

  always #5 clk = ~clk;

  unary_shift_mac dut (
    .clk(clk), .reset_n(reset_n), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
    .in_last(in_last), .in_acc_last(in_acc_last), .in_ready(in_ready), .out(out),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_sat(res_sat)
  );

  unary_shift_mac #(.ACC_BITS(ACC8_W)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
    .in_last(in_last), .in_acc_last(in_acc_last), .in_ready(in_ready8), .out(out8),
    .busy(busy8), .res_valid(res_valid8), .res_ready(res_ready), .res_data(res_data8),
    .res_sat(res_sat8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int clamp_u(input int n);
    return (n > U_MAX) ? U_MAX : n;
  endfunction

  // Offer nbeats accepted beats; the first na carry in_a=1, the first nb carry in_b=1.
  task automatic send_frame(input int na, input int nb, input int nbeats, input bit acc_last,
                            input bit gaps);
    for (int k = 0; k < nbeats; k++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        in_valid = 1'b0;
        in_a     = 1'($urandom);
        in_b     = 1'($urandom);
        in_last  = 1'($urandom);
        step();
      end
      in_valid    = 1'b1;
      in_a        = (k < na);
      in_b        = (k < nb);
      in_last     = (k == nbeats - 1);
      in_acc_last = acc_last;
      step();
      in_valid = 1'b0;
      in_a     = 1'b0;
      in_b     = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  // Starting in the first MULT cycle: expect p consecutive pulses (or one bubble), then silence.
  task automatic run_mult(input int p, input string tag);
    int pulses = 0;
    int pulses8 = 0;
    bit ok = 1'b1;
    int len = (p == 0) ? 1 : p;
    for (int k = 0; k < len; k++) begin
      if (out === 1'b1) pulses++;
      if (out8 === 1'b1) pulses8++;
      if (out !== (k < p)) ok = 1'b0;
      if (busy !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
      step();
    end
    if (out !== 1'b0) ok = 1'b0;
    check({tag, " pulses"}, pulses, p);
    check({tag, " pulses8"}, pulses8, p);
    check({tag, " pulse_shape"}, ok, 1);
  endtask

  task automatic expect_result(input string tag);
    int exp_w = m_sum % (1 << ACC_W);
    int exp8;
    int sat8;
`ifdef UNARY_MAC_SAT_EN
    exp8 = (m_sum > 255) ? 255 : m_sum;
    sat8 = (m_sum > 255) ? 1 : 0;
`else
    exp8 = m_sum % 256;
    sat8 = 0;
`endif
    check({tag, " res_valid"}, res_valid, 1);
    check({tag, " in_ready_res"}, in_ready, 0);
    check({tag, " res_data"}, res_data, exp_w);
    check({tag, " res_sat"}, res_sat, 0);
    check({tag, " res_data8"}, res_data8, exp8);
    check({tag, " res_sat8"}, res_sat8, sat8);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check({tag, " res_valid_drop"}, res_valid, 0);
    check({tag, " in_ready_back"}, in_ready, 1);
    check({tag, " busy_idle"}, busy, 0);
    check({tag, " res_data_kept"}, res_data, exp_w);
    m_sum   = 0;
    m_terms = 0;
  endtask

  task automatic do_pair(input int na, input int nb, input int nbeats, input bit acc_last,
                         input bit gaps, input bit accept_now, input string tag);
    int p = clamp_u(na) * clamp_u(nb);
    send_frame(na, nb, nbeats, acc_last, gaps);
    run_mult(p, tag);
    m_sum += p;
    m_terms++;
    if (acc_last || m_terms == TERMS) begin
      if (accept_now) expect_result(tag);
    end else begin
      check({tag, " in_ready_load"}, in_ready, 1);
      check({tag, " res_valid_load"}, res_valid, 0);
      check({tag, " busy_held"}, busy, 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int na, nb, nbeats;
    bit al;
    reset_n = 1'b0;
    in_a = 1'b0; in_b = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_acc_last = 1'b0;
    res_ready = 1'b0;
    #17;
    check("rst in_ready", in_ready, 1);
    check("rst out", out, 0);
    check("rst busy", busy, 0);
    check("rst res_valid", res_valid, 0);
    check("rst res_data", res_data, 0);
    check("rst res_sat", res_sat, 0);
    reset_n = 1'b1;
    step();

    // (3,5) with a stalled consumer and ignored beats during RESULT
    do_pair(3, 5, 5, 1'b1, 1'b0, 1'b0, "p3x5");
    for (int c = 0; c < 10; c++) begin
      in_valid = (c % 2 == 0);
      in_a = 1'b1; in_b = 1'b1; in_last = 1'b1; in_acc_last = 1'b1;
      step();
      check("hold res_valid", res_valid, 1);
      check("hold res_data", res_data, 15);
      check("hold in_ready", in_ready, 0);
    end
    in_valid = 1'b0; in_a = 1'b0; in_b = 1'b0; in_last = 1'b0;
    expect_result("p3x5");
    do_pair(1, 1, 1, 1'b1, 1'b0, 1'b1, "p1x1");

    // four terms close the accumulation by count
    do_pair(2, 2, 2, 1'b0, 1'b0, 1'b1, "t0");
    do_pair(0, 7, 7, 1'b0, 1'b0, 1'b1, "t1");
    do_pair(16, 16, 16, 1'b0, 1'b0, 1'b1, "t2");
    do_pair(1, 1, 1, 1'b0, 1'b0, 1'b1, "t3");

    // asynchronous reset in the middle of a product
    send_frame(4, 4, 4, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check("pre_rst pulse", out, 1);
      step();
    end
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst out", out, 0);
    check("mid_rst res_valid", res_valid, 0);
    check("mid_rst in_ready", in_ready, 1);
    check("mid_rst busy", busy, 0);
    check("mid_rst res_data", res_data, 0);
    #3 reset_n = 1'b1;
    step();
    m_sum = 0;
    m_terms = 0;
    do_pair(2, 3, 3, 1'b1, 1'b0, 1'b1, "p2x3");

    // full-scale product and overlong frame
    do_pair(16, 16, 16, 1'b1, 1'b0, 1'b1, "p16x16");
    do_pair(20, 20, 20, 1'b1, 1'b0, 1'b1, "over20");

    // random frames with idle gaps carrying garbage
    for (int r = 0; r < 25; r++) begin
      na = $urandom_range(0, 18);
      nb = $urandom_range(0, 18);
      nbeats = ((na > nb) ? na : nb) + $urandom_range(0, 2);
      if (nbeats == 0) nbeats = 1;
      al = ($urandom_range(0, 3) == 0);
      do_pair(na, nb, nbeats, al, 1'b1, 1'b1, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
